// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : draw_arbiter
// Purpose  : Merges NUM_CH independent pixel-drawing engines onto one VGA
//            plot port. Grants one requester per cycle, using fixed or
//            round-robin priority, and registers the winning pixel. Erase
//            requests are turned into the background colour. The exception is
//            the protected column, which is repainted with its own colour so
//            that static UI such as the centre line survives erasing.
// Ports    : clk, reset (async, active-high)
//            enable                     - arbitration enable, low = no grants
//            ch_req/ch_erase [NUM_CH]   - per-channel request / erase flag
//            ch_x/ch_y/ch_colour        - flattened per-channel pixel data
//            ch_ack [NUM_CH]            - registered one-cycle acknowledge
//            plot, x_out, y_out, colour_out - registered pixel write
//            busy                       - any eligible request this cycle
// Revision : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
  parameter int              NUM_CH         = 4,
  parameter int              X_W            = 8,
  parameter int              Y_W            = 7,
  parameter int              C_W            = 3,
  parameter int              RR_MODE        = 1,
  parameter logic [C_W-1:0]  BG_COLOUR      = 3'b000,
  parameter int              PROTECT_EN     = 1,
  parameter logic [X_W-1:0]  PROTECT_X      = 8'd80,
  parameter logic [C_W-1:0]  PROTECT_COLOUR = 3'b111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH-1:0]       ch_erase,
  input  logic [NUM_CH*X_W-1:0]   ch_x,
  input  logic [NUM_CH*Y_W-1:0]   ch_y,
  input  logic [NUM_CH*C_W-1:0]   ch_colour,
  output logic [NUM_CH-1:0]       ch_ack,
  output logic                    plot,
  output logic [X_W-1:0]          x_out,
  output logic [Y_W-1:0]          y_out,
  output logic [C_W-1:0]          colour_out,
  output logic                    busy
);

  localparam int             PTR_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] c_LAST_INIT = PTR_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] r_ack;
  logic              r_plot;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [C_W-1:0]    r_colour;
  logic [PTR_W-1:0]  r_last;

  logic [NUM_CH-1:0] w_elig;
  logic              w_found;
  logic [PTR_W-1:0]  w_win;
  logic [NUM_CH-1:0] w_onehot;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic [C_W-1:0]    w_colour;
  logic              w_erase;
  logic [C_W-1:0]    w_resolved;

  // Index last+k reduced modulo NUM_CH. The channel count need not be a
  // power of two, so plain bit truncation cannot do the wrap.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s[PTR_W-1:0];
  endfunction

  // A channel acked this cycle is still holding the pixel it was just granted.
  // It is masked so that the same pixel is not granted twice.
  assign w_elig = ch_req & ~r_ack & {NUM_CH{enable}};
  assign busy   = |w_elig;

  // Winner selection
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (!w_found && w_elig[wrap_add(r_last, k)]) begin
          w_found = 1'b1;
          w_win   = wrap_add(r_last, k);
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_found && w_elig[i]) begin
          w_found = 1'b1;
          w_win   = i[PTR_W-1:0];
        end
      end
    end
  end

  // Winner data mux
  always_comb begin
    w_x      = '0;
    w_y      = '0;
    w_colour = '0;
    w_erase  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win == i[PTR_W-1:0]) begin
        w_x         = ch_x[i*X_W +: X_W];
        w_y         = ch_y[i*Y_W +: Y_W];
        w_colour    = ch_colour[i*C_W +: C_W];
        w_erase     = ch_erase[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Colour resolution. Only erases are redirected. Draws in the protected
  // column pass through unchanged.
  always_comb begin
    w_resolved = w_colour;
    if (w_erase) begin
      if ((PROTECT_EN != 0) && (w_x == PROTECT_X)) w_resolved = PROTECT_COLOUR;
      else                                         w_resolved = BG_COLOUR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_plot   <= 1'b0;
      r_ack    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_last   <= c_LAST_INIT;
    end else if (w_found) begin
      r_plot   <= 1'b1;
      r_ack    <= w_onehot;
      r_x      <= w_x;
      r_y      <= w_y;
      r_colour <= w_resolved;
      if (RR_MODE != 0) r_last <= w_win;
    end else begin
      // Pixel registers hold so the adapter sees stable data while idle
      r_plot <= 1'b0;
      r_ack  <= '0;
    end
  end

  assign ch_ack     = r_ack;
  assign plot       = r_plot;
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour_out = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_arbiter
// Purpose  : Directed self-checking bench for draw_arbiter. Three instances
//            share one stimulus bus: round-robin with 4 channels, fixed
//            priority with 4 channels, and round-robin with 3 channels (the
//            3-channel instance exercises modulo wrap that is not a power of two).
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  ch_req;
  logic [3:0]  ch_erase;
  logic [31:0] ch_x;
  logic [27:0] ch_y;
  logic [11:0] ch_colour;

  logic [3:0] rr_ack, fx_ack;
  logic [2:0] t3_ack;
  logic       rr_plot, fx_plot, t3_plot;
  logic [7:0] rr_x, fx_x, t3_x;
  logic [6:0] rr_y, fx_y, t3_y;
  logic [2:0] rr_col, fx_col, t3_col;
  logic       rr_busy, fx_busy, t3_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  draw_arbiter #(.NUM_CH(4), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .enable(enable),
    .ch_req(ch_req), .ch_erase(ch_erase), .ch_x(ch_x), .ch_y(ch_y),
    .ch_colour(ch_colour), .ch_ack(rr_ack), .plot(rr_plot), .x_out(rr_x),
    .y_out(rr_y), .colour_out(rr_col), .busy(rr_busy));

  draw_arbiter #(.NUM_CH(4), .RR_MODE(0)) dut_fx (
    .clk(clk), .reset(reset), .enable(enable),
    .ch_req(ch_req), .ch_erase(ch_erase), .ch_x(ch_x), .ch_y(ch_y),
    .ch_colour(ch_colour), .ch_ack(fx_ack), .plot(fx_plot), .x_out(fx_x),
    .y_out(fx_y), .colour_out(fx_col), .busy(fx_busy));

  draw_arbiter #(.NUM_CH(3), .RR_MODE(1)) dut_t3 (
    .clk(clk), .reset(reset), .enable(enable),
    .ch_req(ch_req[2:0]), .ch_erase(ch_erase[2:0]), .ch_x(ch_x[23:0]),
    .ch_y(ch_y[20:0]), .ch_colour(ch_colour[8:0]), .ch_ack(t3_ack),
    .plot(t3_plot), .x_out(t3_x), .y_out(t3_y), .colour_out(t3_col),
    .busy(t3_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic req, input logic erase,
                        input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] col);
    ch_req[i]          = req;
    ch_erase[i]        = erase;
    ch_x[i*8 +: 8]     = x;
    ch_y[i*7 +: 7]     = y;
    ch_colour[i*3 +: 3] = col;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    ch_req    = '0;
    ch_erase  = '0;
    ch_x      = '0;
    ch_y      = '0;
    ch_colour = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rr_plot, rr_ack, rr_x, rr_y, rr_col} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want 0", {rr_plot, rr_ack, rr_x, rr_y, rr_col});
    end
    // Traffic, then asynchronous reset between edges
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 8'(10*(i+1)), 7'(i+3), 3'(i+1));
    tick();
    tick();
    n_cmp++;
    if (rr_plot !== 1'b1 || rr_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_pre_traffic: got plot=%b ack=%b want 1/0010", rr_plot, rr_ack);
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rr_plot, rr_ack, rr_x, rr_y, rr_col} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0", {rr_plot, rr_ack, rr_x, rr_y, rr_col});
    end
    n_cmp++;
    if ({fx_plot, fx_ack, fx_x, fx_y, fx_col} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_async_fx: got %h want 0", {fx_plot, fx_ack, fx_x, fx_y, fx_col});
    end
    #1 reset = 1'b0;
    tick();
    n_cmp++;
    if ({rr_plot, rr_ack, rr_x, rr_y, rr_col} !== {1'b1, 4'b0001, 8'd10, 7'd3, 3'd1}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got plot=%b ack=%b x=%0d y=%0d c=%0d want 1 0001 10 3 1",
               rr_plot, rr_ack, rr_x, rr_y, rr_col);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp4_x[5]   = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd10};
    logic [3:0] exp4_ack[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp3_x[5]   = '{8'd10, 8'd20, 8'd30, 8'd10, 8'd20};
    logic [2:0] exp3_ack[5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 8'(10*(i+1)), 7'(i), 3'(i));
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (rr_plot !== 1'b1 || rr_ack !== exp4_ack[c] || rr_x !== exp4_x[c]) begin
        n_fail++;
        $display("FAIL rr4_cycle%0d: got plot=%b ack=%b x=%0d want 1 %b %0d",
                 c, rr_plot, rr_ack, rr_x, exp4_ack[c], exp4_x[c]);
      end
      n_cmp++;
      if (t3_plot !== 1'b1 || t3_ack !== exp3_ack[c] || t3_x !== exp3_x[c]) begin
        n_fail++;
        $display("FAIL rr3_cycle%0d: got plot=%b ack=%b x=%0d want 1 %b %0d",
                 c, t3_plot, t3_ack, t3_x, exp3_ack[c], exp3_x[c]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_ch(1, 1'b1, 1'b0, 8'd21, 7'd1, 3'd1);
    set_ch(3, 1'b1, 1'b0, 8'd43, 7'd3, 3'd3);
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (fx_plot !== 1'b1 || fx_ack !== ((c % 2 == 0) ? 4'b0010 : 4'b1000) ||
          fx_x !== ((c % 2 == 0) ? 8'd21 : 8'd43)) begin
        n_fail++;
        $display("FAIL fixed_cycle%0d: got plot=%b ack=%b x=%0d want 1 %b %0d",
                 c, fx_plot, fx_ack, fx_x, (c % 2 == 0) ? 4'b0010 : 4'b1000,
                 (c % 2 == 0) ? 21 : 43);
      end
    end
  endtask

  task automatic test_colour();
    logic       er[3]  = '{1'b1, 1'b1, 1'b0};
    logic [7:0] xs[3]  = '{8'd80, 8'd79, 8'd80};
    logic [2:0] exp[3] = '{3'b111, 3'b000, 3'b101};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_ch(2, 1'b1, er[c], xs[c], 7'd9, 3'b101);
      tick();
      n_cmp++;
      if (fx_plot !== 1'b1 || fx_ack !== 4'b0100 || fx_col !== exp[c] || fx_x !== xs[c]) begin
        n_fail++;
        $display("FAIL colour_case%0d: got plot=%b ack=%b x=%0d c=%b want 1 0100 %0d %b",
                 c, fx_plot, fx_ack, fx_x, fx_col, xs[c], exp[c]);
      end
      n_cmp++;
      if (rr_col !== exp[c]) begin
        n_fail++;
        $display("FAIL colour_rr_case%0d: got c=%b want %b", c, rr_col, exp[c]);
      end
      ch_req[2] = 1'b0;
      tick();
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    set_ch(0, 1'b1, 1'b0, 8'd7, 7'd5, 3'd2);
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (rr_plot !== (c % 2 == 0) || rr_ack !== ((c % 2 == 0) ? 4'b0001 : 4'b0000) ||
          rr_y !== 7'd5 || rr_busy !== (c % 2 == 1)) begin
        n_fail++;
        $display("FAIL single_cycle%0d: got plot=%b ack=%b y=%0d busy=%b want %b %b 5 %b",
                 c, rr_plot, rr_ack, rr_y, rr_busy, c % 2 == 0,
                 (c % 2 == 0) ? 4'b0001 : 4'b0000, c % 2 == 1);
      end
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    enable = 1'b0;
    set_ch(1, 1'b1, 1'b0, 8'd33, 7'd44, 3'd6);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (rr_plot !== 1'b0 || rr_ack !== 4'b0000 || rr_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_off%0d: got plot=%b ack=%b busy=%b want 0 0000 0",
                 c, rr_plot, rr_ack, rr_busy);
      end
    end
    enable = 1'b1;
    #1;
    n_cmp++;
    if (rr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_busy: got %b want 1", rr_busy);
    end
    tick();
    n_cmp++;
    if ({rr_plot, rr_ack, rr_x, rr_y, rr_col} !== {1'b1, 4'b0010, 8'd33, 7'd44, 3'd6}) begin
      n_fail++;
      $display("FAIL enable_resume: got plot=%b ack=%b x=%0d y=%0d c=%0d want 1 0010 33 44 6",
               rr_plot, rr_ack, rr_x, rr_y, rr_col);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_colour();
    test_single_channel();
    test_enable_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
Parametrised pixel-draw arbiter that merges NUM_CH independent drawing engines (init, UI, paddles, ball, future sprites) onto the single VGA plot port. Each channel presents a pixel request with coordinates, colour and an erase flag. The arbiter grants one channel per cycle, using fixed or round-robin priority, and registers the winning pixel. It applies erase-colour substitution and a protected-column rule, so erasing never damages static UI such as the centre line.

Parameters:
NUM_CH, 4, number of request channels (2..8)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width
RR_MODE, 1, 1 = round-robin priority, 0 = fixed priority (lowest index wins)
BG_COLOUR, 3'b000, colour written for erase requests
PROTECT_EN, 1, enable protected-column substitution
PROTECT_X, 8'd80, protected column
PROTECT_COLOUR, 3'b111, colour written when erasing inside the protected column

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  arbitration enable; low = no grants
ch_req  in  NUM_CH  per-channel pixel request, held until acked
ch_erase  in  NUM_CH  per-channel erase flag (1 = write background)
ch_x  in  NUM_CH*X_W  flattened x; channel i at [i*X_W +: X_W]
ch_y  in  NUM_CH*Y_W  flattened y; channel i at [i*Y_W +: Y_W]
ch_colour  in  NUM_CH*C_W  flattened draw colour
ch_ack  out  NUM_CH  one-cycle acknowledge, one-hot or zero
plot  out  1  registered pixel-write strobe to VGA adapter
x_out  out  X_W  registered pixel x
y_out  out  Y_W  registered pixel y
colour_out  out  C_W  registered pixel colour
busy  out  1  combinational: any unmasked ch_req high while enable high

Behaviour:
- Reset (async, active-high):
  - plot, x_out, y_out, colour_out, ch_ack all 0.
  - Round-robin pointer last = NUM_CH-1, so channel 0 has first priority.
- Eligibility each cycle: elig[i] = ch_req[i] & ~ch_ack[i] & enable.
  - A channel acked in this cycle is masked for that cycle, which prevents a double grant while the requester drops or updates its request.
- Selection:
  - Fixed mode: lowest-index eligible channel wins.
  - RR mode: the first eligible channel searching last+1, last+2, … modulo NUM_CH wins.
  - Index arithmetic wraps at NUM_CH, not at a power of two.
- Latency: 1 cycle. On the posedge after channel w is eligible and selected:
  - plot <= 1; ch_ack <= one-hot(w).
  - x_out <= ch_x[w]; y_out <= ch_y[w].
  - colour_out <= resolved colour.
  - In RR mode, last <= w.
- No eligible channel: plot <= 0 and ch_ack <= 0. x_out, y_out and colour_out hold their values, and last holds.
- Colour resolution, evaluated on the winner:
  - erase=0: ch_colour[w].
  - erase=1 and PROTECT_EN and ch_x[w]==PROTECT_X: PROTECT_COLOUR.
  - erase=1 otherwise: BG_COLOUR.
  - Draw requests in the protected column are unaffected.
- Requester contract: hold req, x, y, colour and erase stable from assertion until the cycle ch_ack is seen high. It may change them, or keep req high for a new pixel, on the following cycle.
- Sustained throughput:
  - One pixel per cycle when two or more channels are requesting.
  - A single continuously requesting channel is served every other cycle, because of the ack mask.
- enable deassert mid-stream:
  - The next edge produces plot=0 and ch_ack=0; pending requests stay pending and none are lost.
  - A grant already registered (plot=1 in this cycle) completes normally.
- Reset mid-operation: any in-flight pixel is dropped and ack is not issued; requesters re-present after reset.
- Fixed mode may starve high indices by design. RR mode guarantees each continuously requesting channel a grant within NUM_CH grants.

Test Plan:
- Reset asserted during traffic -> plot=0, x_out=0, y_out=0, colour_out=0, ch_ack=0 immediately (asynchronous); first grant after release goes to ch0 when ch0..3 all request.
- RR_MODE=1, NUM_CH=4, all req held high with distinct x (10,20,30,40) -> plot every cycle, x_out sequence 10,20,30,40,10 …, ch_ack one-hot 0001,0010,0100,1000.
- RR_MODE=0, ch1 and ch3 req high -> ch1 acked on alternating cycles; ch3 granted only in the masked cycles (x_out alternates ch1, ch3).
- ch2 erase=1, x=80, colour=3'b101 -> colour_out=3'b111. Same with x=79 -> colour_out=3'b000. Same with erase=0 and x=80 -> 3'b101.
- Single channel ch0 req held with y=5 -> plot pattern 1,0,1,0; ch_ack[0] pulses every second cycle; no double grant.
- enable dropped for 3 cycles with ch1 requesting -> plot=0 and ch_ack=0 for those cycles; ch1 granted on the first edge after enable returns, with x, y and colour intact.
